id_ex_stage: RTL and testbench

- Decode stage plus ID/EX pipeline register of the 5-stage RV32I pipeline.
- Takes the instruction from IF/ID and drives the register-file read addresses. It captures the returned operands, immediate and control bits into the ID/EX register for EX.
- Detects load-use hazards, inserts bubbles, honours EX flush/hold, and counts stall cycles.

---
 rtl/rv_pkg.sv | 50 +++++
 rtl/imm_gen.sv | 26 ++
 rtl/id_ex_stage.sv | 184 ++++++++++++++++++
 tb/tb_id_ex_stage.sv | 291 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/rv_pkg.sv
// Shared RV32I decode definitions: opcodes, control bundle and immediate formats.
package rv_pkg;

    localparam int unsigned XLEN = 32;
    localparam int unsigned ILEN = 32;
    localparam int unsigned RAW  = 5;

    localparam logic [6:0] OPC_R      = 7'b0110011;
    localparam logic [6:0] OPC_IMM    = 7'b0010011;
    localparam logic [6:0] OPC_LOAD   = 7'b0000011;
    localparam logic [6:0] OPC_STORE  = 7'b0100011;
    localparam logic [6:0] OPC_BRANCH = 7'b1100011;
    localparam logic [6:0] OPC_LUI    = 7'b0110111;
    localparam logic [6:0] OPC_JAL    = 7'b1101111;

    // Control bundle carried through ID/EX, MSB first.
    typedef struct packed {
        logic reg_write;
        logic mem_read;
        logic mem_write;
        logic branch;
        logic jump;
        logic alu_src;
        logic mem_to_reg;
        logic illegal;
    } ctrl_t;

    typedef enum logic [2:0] {
        IMM_NONE,
        IMM_I,
        IMM_S,
        IMM_B,
        IMM_U,
        IMM_J
    } imm_sel_e;

    function automatic imm_sel_e imm_sel(input logic [6:0] opcode);
        imm_sel_e sel;
        case (opcode)
            OPC_IMM, OPC_LOAD: sel = IMM_I;
            OPC_STORE:         sel = IMM_S;
            OPC_BRANCH:        sel = IMM_B;
            OPC_LUI:           sel = IMM_U;
            OPC_JAL:           sel = IMM_J;
            default:           sel = IMM_NONE;
        endcase
        return sel;
    endfunction

endpackage

// File: rtl/imm_gen.sv
// Immediate generator: assembles and sign-extends the RV32I immediate for the opcode's format.
module imm_gen
    import rv_pkg::*;
#(
    parameter int unsigned N = XLEN
) (
    input  logic [ILEN-1:0] instr,
    output logic [N-1:0]    imm_c
);

    logic [ILEN-1:0] imm32;

    always_comb begin
        imm32 = '0;
        case (imm_sel(instr[6:0]))
            IMM_I:   imm32 = {{20{instr[31]}}, instr[31:20]};
            IMM_S:   imm32 = {{20{instr[31]}}, instr[31:25], instr[11:7]};
            IMM_B:   imm32 = {{19{instr[31]}}, instr[31], instr[7], instr[30:25], instr[11:8], 1'b0};
            IMM_U:   imm32 = {instr[31:12], 12'b0};
            IMM_J:   imm32 = {{11{instr[31]}}, instr[31], instr[19:12], instr[20], instr[30:21], 1'b0};
            default: imm32 = '0;
        endcase
        imm_c = N'($signed(imm32));
    end

endmodule

// File: rtl/id_ex_stage.sv
// RV32I decode stage and ID/EX pipeline register with load-use stall, flush/hold and stall counter.
module id_ex_stage
    import rv_pkg::*;
#(
    parameter int unsigned N = 32
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            id_valid,
    input  logic [31:0]     id_instr,
    input  logic [N-1:0]    id_pc,
    output logic [4:0]      rf_src1,
    output logic [4:0]      rf_src2,
    input  logic [N-1:0]    rf_data1,
    input  logic [N-1:0]    rf_data2,
    input  logic            ex_flush,
    input  logic            ex_hold,
    output logic            id_stall,
    output logic            ex_valid,
    output logic [N-1:0]    ex_pc,
    output logic [N-1:0]    ex_rs1_val,
    output logic [N-1:0]    ex_rs2_val,
    output logic [N-1:0]    ex_imm,
    output logic [4:0]      ex_rs1,
    output logic [4:0]      ex_rs2,
    output logic [4:0]      ex_rd,
    output logic [2:0]      ex_funct3,
    output logic            ex_funct7b5,
    output logic            ex_reg_write,
    output logic            ex_mem_read,
    output logic            ex_mem_write,
    output logic            ex_branch,
    output logic            ex_jump,
    output logic            ex_alu_src,
    output logic            ex_mem_to_reg,
    output logic            ex_illegal,
    output logic [31:0]     stall_cnt
);

    localparam int unsigned CNT_W = 32;

    typedef struct packed {
        logic           valid;
        logic [N-1:0]   pc;
        logic [N-1:0]   rs1_val;
        logic [N-1:0]   rs2_val;
        logic [N-1:0]   imm;
        logic [RAW-1:0] rs1;
        logic [RAW-1:0] rs2;
        logic [RAW-1:0] rd;
        logic [2:0]     funct3;
        logic           funct7b5;
        ctrl_t          ctrl;
    } idex_t;

    idex_t        q;
    idex_t        d;
    ctrl_t        ctrl;
    logic         uses_rs1;
    logic         uses_rs2;
    logic         hazard;
    logic [N-1:0] imm;

    assign rf_src1 = id_instr[19:15];
    assign rf_src2 = id_instr[24:20];

    imm_gen #(.N(N)) u_imm_gen (
        .instr (id_instr),
        .imm_c (imm)
    );

    // Opcode decode: control bundle and which source registers are actually read.
    always_comb begin
        ctrl     = '0;
        uses_rs1 = 1'b0;
        uses_rs2 = 1'b0;
        case (id_instr[6:0])
            OPC_R: begin
                ctrl.reg_write = 1'b1;
                uses_rs1       = 1'b1;
                uses_rs2       = 1'b1;
            end
            OPC_IMM: begin
                ctrl.reg_write = 1'b1;
                ctrl.alu_src   = 1'b1;
                uses_rs1       = 1'b1;
            end
            OPC_LOAD: begin
                ctrl.reg_write  = 1'b1;
                ctrl.mem_read   = 1'b1;
                ctrl.mem_to_reg = 1'b1;
                ctrl.alu_src    = 1'b1;
                uses_rs1        = 1'b1;
            end
            OPC_STORE: begin
                ctrl.mem_write = 1'b1;
                ctrl.alu_src   = 1'b1;
                uses_rs1       = 1'b1;
                uses_rs2       = 1'b1;
            end
            OPC_BRANCH: begin
                ctrl.branch = 1'b1;
                uses_rs1    = 1'b1;
                uses_rs2    = 1'b1;
            end
            OPC_LUI: begin
                ctrl.reg_write = 1'b1;
                ctrl.alu_src   = 1'b1;
            end
            OPC_JAL: begin
                ctrl.reg_write = 1'b1;
                ctrl.jump      = 1'b1;
            end
            default: ctrl.illegal = 1'b1;
        endcase
    end

    // Load in EX whose destination feeds a source this instruction really reads.
    assign hazard = id_valid && q.valid && q.ctrl.mem_read && (q.rd != '0) &&
                    (((q.rd == rf_src1) && uses_rs1) || ((q.rd == rf_src2) && uses_rs2));

    assign id_stall = ex_hold || (hazard && !ex_flush);

    // Next ID/EX entry: flush beats hold, hold beats bubble-on-hazard, else capture.
    always_comb begin
        d = q;
        if (ex_flush) begin
            d = '0;
        end else if (!ex_hold) begin
            if (hazard || !id_valid) begin
                d = '0;
            end else begin
                d.valid    = 1'b1;
                d.pc       = id_pc;
                d.rs1_val  = rf_data1;
                d.rs2_val  = rf_data2;
                d.imm      = imm;
                d.rs1      = rf_src1;
                d.rs2      = rf_src2;
                d.rd       = ctrl.reg_write ? id_instr[11:7] : '0;
                d.funct3   = id_instr[14:12];
                d.funct7b5 = id_instr[30];
                d.ctrl     = ctrl;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            q <= '0;
        end else begin
            q <= d;
        end
    end

    // Saturating stall counter.
    always_ff @(posedge clk) begin
        if (rst) begin
            stall_cnt <= '0;
        end else if (id_stall && (stall_cnt != {CNT_W{1'b1}})) begin
            stall_cnt <= stall_cnt + CNT_W'(1);
        end
    end

    assign ex_valid      = q.valid;
    assign ex_pc         = q.pc;
    assign ex_rs1_val    = q.rs1_val;
    assign ex_rs2_val    = q.rs2_val;
    assign ex_imm        = q.imm;
    assign ex_rs1        = q.rs1;
    assign ex_rs2        = q.rs2;
    assign ex_rd         = q.rd;
    assign ex_funct3     = q.funct3;
    assign ex_funct7b5   = q.funct7b5;
    assign ex_reg_write  = q.ctrl.reg_write;
    assign ex_mem_read   = q.ctrl.mem_read;
    assign ex_mem_write  = q.ctrl.mem_write;
    assign ex_branch     = q.ctrl.branch;
    assign ex_jump       = q.ctrl.jump;
    assign ex_alu_src    = q.ctrl.alu_src;
    assign ex_mem_to_reg = q.ctrl.mem_to_reg;
    assign ex_illegal    = q.ctrl.illegal;

endmodule

// File: tb/tb_id_ex_stage.sv
// Bench for id_ex_stage: directed literal checks plus randomized traffic against a behavioural model.
module tb_id_ex_stage;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        id_valid = 1'b0;
    logic [31:0] id_instr = 32'h0;
    logic [31:0] id_pc = 32'h0;
    logic [4:0]  rf_src1, rf_src2;
    logic [31:0] rf_data1, rf_data2;
    logic        ex_flush = 1'b0;
    logic        ex_hold = 1'b0;
    logic        id_stall, ex_valid;
    logic [31:0] ex_pc, ex_rs1_val, ex_rs2_val, ex_imm;
    logic [4:0]  ex_rs1, ex_rs2, ex_rd;
    logic [2:0]  ex_funct3;
    logic        ex_funct7b5;
    logic        ex_reg_write, ex_mem_read, ex_mem_write, ex_branch, ex_jump, ex_alu_src, ex_mem_to_reg, ex_illegal;
    logic [31:0] stall_cnt;

    logic [31:0] rf [32];
    assign rf_data1 = rf[rf_src1];
    assign rf_data2 = rf[rf_src2];

    id_ex_stage #(.N(32)) dut (
        .clk(clk), .rst(rst), .id_valid(id_valid), .id_instr(id_instr), .id_pc(id_pc),
        .rf_src1(rf_src1), .rf_src2(rf_src2), .rf_data1(rf_data1), .rf_data2(rf_data2),
        .ex_flush(ex_flush), .ex_hold(ex_hold), .id_stall(id_stall), .ex_valid(ex_valid),
        .ex_pc(ex_pc), .ex_rs1_val(ex_rs1_val), .ex_rs2_val(ex_rs2_val), .ex_imm(ex_imm),
        .ex_rs1(ex_rs1), .ex_rs2(ex_rs2), .ex_rd(ex_rd), .ex_funct3(ex_funct3), .ex_funct7b5(ex_funct7b5),
        .ex_reg_write(ex_reg_write), .ex_mem_read(ex_mem_read), .ex_mem_write(ex_mem_write),
        .ex_branch(ex_branch), .ex_jump(ex_jump), .ex_alu_src(ex_alu_src), .ex_mem_to_reg(ex_mem_to_reg),
        .ex_illegal(ex_illegal), .stall_cnt(stall_cnt)
    );

    initial forever #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    task automatic chk(input string name, input logic [159:0] act, input logic [159:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s act=%0h exp=%0h at %0t", name, act, exp, $time);
        end
    endtask

    // Control vector order: reg_write mem_read mem_write branch jump alu_src mem_to_reg illegal
    logic [7:0] dut_ctl;
    assign dut_ctl = {ex_reg_write, ex_mem_read, ex_mem_write, ex_branch, ex_jump, ex_alu_src, ex_mem_to_reg, ex_illegal};

    typedef struct packed {
        logic [7:0]  ctl;
        logic        u1;
        logic        u2;
        logic [31:0] imm;
    } dec_t;

    // Instruction semantics straight from the ISA tables, immediates by integer arithmetic.
    function automatic dec_t decode(input logic [31:0] i);
        dec_t e;
        int   s;
        int   v;
        s = int'($signed(i));
        v = 0;
        e.u1 = 1'b0;
        e.u2 = 1'b0;
        case (i[6:0])
            7'b0110011: begin e.ctl = 8'b1000_0000; e.u1 = 1'b1; e.u2 = 1'b1; end
            7'b0010011: begin e.ctl = 8'b1000_0100; e.u1 = 1'b1; v = s >>> 20; end
            7'b0000011: begin e.ctl = 8'b1100_0110; e.u1 = 1'b1; v = s >>> 20; end
            7'b0100011: begin
                e.ctl = 8'b0010_0100; e.u1 = 1'b1; e.u2 = 1'b1;
                v = (s >>> 25) * 32 + int'(i[11:7]);
            end
            7'b1100011: begin
                e.ctl = 8'b0001_0000; e.u1 = 1'b1; e.u2 = 1'b1;
                v = (i[31] ? -4096 : 0) + int'(i[7]) * 2048 + int'(i[30:25]) * 32 + int'(i[11:8]) * 2;
            end
            7'b0110111: begin e.ctl = 8'b1000_0100; v = int'(i & 32'hFFFF_F000); end
            7'b1101111: begin
                e.ctl = 8'b1000_1000;
                v = (i[31] ? -1048576 : 0) + int'(i[19:12]) * 4096 + int'(i[20]) * 2048 + int'(i[30:21]) * 2;
            end
            default: e.ctl = 8'b0000_0001;
        endcase
        e.imm = 32'(v);
        return e;
    endfunction

    // Model of the ID/EX entry and counter.
    logic        m_valid = 1'b0;
    logic [7:0]  m_ctl = 8'h0;
    logic [31:0] m_pc = 0, m_v1 = 0, m_v2 = 0, m_imm = 0;
    logic [4:0]  m_rs1 = 0, m_rs2 = 0, m_rd = 0;
    logic [2:0]  m_f3 = 0;
    logic        m_f7 = 0;
    logic [31:0] m_cnt = 0;
    logic        m_last_stall = 1'b0;

    function automatic logic exp_haz();
        dec_t e;
        logic [4:0] a, b;
        e = decode(id_instr);
        a = id_instr[19:15];
        b = id_instr[24:20];
        return id_valid && m_valid && m_ctl[6] && (m_rd != 5'd0) &&
               (((m_rd == a) && e.u1) || ((m_rd == b) && e.u2));
    endfunction

    function automatic logic exp_stall();
        return ex_hold || (exp_haz() && !ex_flush);
    endfunction

    task automatic m_bubble();
        m_valid = 1'b0; m_ctl = 8'h0; m_pc = 0; m_v1 = 0; m_v2 = 0; m_imm = 0;
        m_rs1 = 0; m_rs2 = 0; m_rd = 0; m_f3 = 0; m_f7 = 0;
    endtask

    initial begin
        logic st, hz;
        dec_t e;
        forever begin
            @(posedge clk);
            if (rst) begin
                m_bubble();
                m_cnt = 0;
                m_last_stall = 1'b0;
            end else begin
                st = exp_stall();
                hz = exp_haz();
                if (st && (m_cnt != 32'hFFFF_FFFF)) m_cnt = m_cnt + 1;
                if (ex_flush) m_bubble();
                else if (ex_hold) begin end
                else if (hz || !id_valid) m_bubble();
                else begin
                    e = decode(id_instr);
                    m_valid = 1'b1; m_ctl = e.ctl; m_pc = id_pc; m_imm = e.imm;
                    m_v1 = rf[id_instr[19:15]]; m_v2 = rf[id_instr[24:20]];
                    m_rs1 = id_instr[19:15]; m_rs2 = id_instr[24:20];
                    m_rd = e.ctl[7] ? id_instr[11:7] : 5'd0;
                    m_f3 = id_instr[14:12]; m_f7 = id_instr[30];
                end
                m_last_stall = st;
            end
        end
    end

    // Compare DUT against the model every cycle, on the falling edge.
    initial begin
        @(posedge clk);
        forever begin
            @(negedge clk);
            chk("id_stall", 160'(id_stall), 160'(exp_stall()));
            chk("rf_src", 160'({rf_src1, rf_src2}), 160'({id_instr[19:15], id_instr[24:20]}));
            chk("ex_valid", 160'(ex_valid), 160'(m_valid));
            chk("ctrl", 160'(dut_ctl), 160'(m_ctl));
            chk("stall_cnt", 160'(stall_cnt), 160'(m_cnt));
            if (m_valid)
                chk("payload",
                    160'({ex_pc, ex_rs1_val, ex_rs2_val, ex_imm, ex_rs1, ex_rs2, ex_rd, ex_funct3, ex_funct7b5}),
                    160'({m_pc, m_v1, m_v2, m_imm, m_rs1, m_rs2, m_rd, m_f3, m_f7}));
        end
    end

    // One clock edge, then present the next ID inputs.
    task automatic cyc(input logic v, input logic [31:0] ins, input logic fl, input logic hd);
        @(posedge clk);
        #1;
        id_valid = v; id_instr = ins; id_pc = $urandom; ex_flush = fl; ex_hold = hd;
        #1;
    endtask

    function automatic logic [31:0] rand_instr();
        logic [31:0] r;
        r = $urandom;
        case ($urandom_range(0, 10))
            0: r[6:0] = 7'b0110011;
            1: r[6:0] = 7'b0010011;
            2: r[6:0] = 7'b0100011;
            3: r[6:0] = 7'b1100011;
            4: r[6:0] = 7'b0110111;
            5: r[6:0] = 7'b1101111;
            6: r[6:0] = 7'b1111111;
            7: r[6:0] = 7'b1100111;
            default: r[6:0] = 7'b0000011;
        endcase
        r[11:7]  = 5'($urandom_range(0, 7));
        r[19:15] = 5'($urandom_range(0, 7));
        r[24:20] = 5'($urandom_range(0, 7));
        return r;
    endfunction

    localparam logic [31:0] ADD1   = 32'h0031_00B3; // add x1,x2,x3
    localparam logic [31:0] LW5    = 32'h0000_A283; // lw x5,0(x1)
    localparam logic [31:0] ADD6   = 32'h0072_8333; // add x6,x5,x7
    localparam logic [31:0] LW0    = 32'h0000_A003; // lw x0,0(x1)
    localparam logic [31:0] ADD6_0 = 32'h0070_0333; // add x6,x0,x7
    localparam logic [31:0] ADDI6  = 32'h0054_0313; // addi x6,x8,5
    localparam logic [31:0] LUI5   = 32'h1234_52B7; // lui x5,0x12345
    localparam logic [31:0] SW     = 32'hFE21_AE23; // sw x2,-4(x3)
    localparam logic [31:0] BEQ    = 32'hFE20_8CE3; // beq x1,x2,-8
    localparam logic [31:0] JAL    = 32'h0010_00EF; // jal x1,+2048
    localparam logic [31:0] ILL    = 32'h0000_007F;

    initial begin
        rf[0] = 32'h0;
        for (int r = 1; r < 32; r++) rf[r] = $urandom;

        // Reset holds the stage empty even with a valid instruction offered.
        rst = 1'b1;
        cyc(1'b1, ADD1, 1'b0, 1'b0);
        cyc(1'b1, ADD1, 1'b0, 1'b0);
        chk("rst_valid", 160'(ex_valid), 160'(0));
        chk("rst_cnt", 160'(stall_cnt), 160'(0));
        rst = 1'b0;
        cyc(1'b1, LW5, 1'b0, 1'b0);
        chk("rel_valid_rd_rw", 160'({ex_valid, ex_rd, ex_reg_write}), 160'({1'b1, 5'd1, 1'b1}));

        // Load-use: one stall, one bubble, then the dependent add issues.
        cyc(1'b1, ADD6, 1'b0, 1'b0);
        chk("lu_stall", 160'(id_stall), 160'(1));
        cyc(1'b1, ADD6, 1'b0, 1'b0);
        chk("lu_bubble", 160'({ex_valid, id_stall}), 160'(0));
        cyc(1'b1, LW0, 1'b0, 1'b0);
        chk("lu_issue", 160'({ex_valid, ex_rs1, ex_rs2}), 160'({1'b1, 5'd5, 5'd7}));
        chk("lu_cnt", 160'(stall_cnt), 160'(1));

        // No false hazards.
        cyc(1'b1, ADD6_0, 1'b0, 1'b0);
        chk("nohz_x0", 160'(id_stall), 160'(0));
        cyc(1'b1, LW5, 1'b0, 1'b0);
        cyc(1'b1, ADDI6, 1'b0, 1'b0);
        chk("nohz_addi", 160'(id_stall), 160'(0));
        cyc(1'b1, LW5, 1'b0, 1'b0);
        cyc(1'b1, LUI5, 1'b0, 1'b0);
        chk("nohz_lui", 160'(id_stall), 160'(0));
        cyc(1'b1, LW5, 1'b0, 1'b0);
        chk("lui_imm", 160'({ex_valid, ex_rd, ex_imm}), 160'({1'b1, 5'd5, 32'h1234_5000}));

        // Flush beats a pending load-use hazard.
        cyc(1'b1, ADD6, 1'b1, 1'b0);
        chk("flush_stall", 160'(id_stall), 160'(0));
        cyc(1'b1, SW, 1'b0, 1'b0);
        chk("flush_bubble", 160'(ex_valid), 160'(0));

        // Hold freezes a store in ID/EX for three cycles.
        cyc(1'b0, 32'h13, 1'b0, 1'b1);
        for (int k = 0; k < 3; k++) begin
            chk("hold_stall", 160'(id_stall), 160'(1));
            chk("hold_sw", 160'({ex_valid, ex_mem_write, ex_imm, ex_rs1, ex_rs2}),
                160'({1'b1, 1'b1, 32'hFFFF_FFFC, 5'd3, 5'd2}));
            if (k < 2) cyc(1'b0, 32'h13, 1'b0, 1'b1);
        end
        cyc(1'b1, BEQ, 1'b0, 1'b0);
        chk("hold_end_sw", 160'({ex_mem_write, ex_imm}), 160'({1'b1, 32'hFFFF_FFFC}));
        chk("hold_cnt", 160'(stall_cnt), 160'(4));

        // Immediates and illegal opcode.
        cyc(1'b1, JAL, 1'b0, 1'b0);
        chk("beq", 160'({ex_branch, ex_imm}), 160'({1'b1, 32'hFFFF_FFF8}));
        cyc(1'b1, ILL, 1'b0, 1'b0);
        chk("jal", 160'({ex_jump, ex_reg_write, ex_rd, ex_imm}), 160'({1'b1, 1'b1, 5'd1, 32'h0000_0800}));
        cyc(1'b0, 32'h13, 1'b0, 1'b0);
        chk("illegal", 160'({ex_valid, dut_ctl}), 160'({1'b1, 8'b0000_0001}));

        // Randomized traffic; IF holds its instruction whenever the stage stalled.
        for (int c = 0; c < 3000; c++) begin
            @(posedge clk);
            #1;
            rst = ($urandom_range(0, 199) == 0);
            if (!m_last_stall) begin
                id_valid = ($urandom_range(0, 9) != 0);
                id_instr = rand_instr();
                id_pc    = $urandom;
            end
            ex_flush = ($urandom_range(0, 9) == 0);
            ex_hold  = ($urandom_range(0, 7) == 0);
        end
        @(posedge clk);
        #1;
        rst = 1'b0; id_valid = 1'b0; ex_flush = 1'b0; ex_hold = 1'b0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        #1;
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
